// File: rtl/leb128_pkg.sv
// Shared types for the LEB128 immediate fetch unit: FSM states, error codes
// and the encoded-length helper.
package leb128_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LATCH  = 3'd2,
    DECODE = 3'd3,
    DONE   = 3'd4
  } fetch_state_t;

  typedef enum logic [1:0] {
    OK       = 2'd0,
    MEM      = 2'd1,
    TOO_LONG = 2'd2,
    RANGE    = 2'd3
  } leb_err_t;

  // Longest legal LEB128 encoding of a bits-wide value.
  function automatic int max_bytes(input int bits);
    return (bits + 6) / 7;
  endfunction

endpackage

// File: rtl/leb128_final_check.sv
// Terminating-byte analysis: range check of the last allowed byte and the
// sign-extension mask applied to the assembled value.
module leb128_final_check #(
  parameter int MAX_BITS = 64
) (
  input  logic [6:0]          payload,
  input  logic [3:0]          index,
  input  logic                is_64,
  input  logic                is_signed,
  output logic                range_err,
  output logic [MAX_BITS-1:0] ext_mask
);

  logic [3:0] last_index;
  logic [6:0] upper_mask;
  logic [6:0] upper_bits;
  logic       sign_bit;
  logic [7:0] shamt;

  // Classify the terminating byte and build the mask of bits to force to one
  always_comb begin
    last_index = is_64 ? 4'd9 : 4'd4;
    upper_mask = is_64 ? 7'h7E : 7'h70;
    sign_bit   = is_64 ? payload[0] : payload[3];
    upper_bits = payload & upper_mask;
    range_err  = 1'b0;
    ext_mask   = '0;
    shamt      = 8'd0;
    if (index == last_index) begin
      // Bits beyond N-1 must be a pure extension of bit N-1 (or zero when unsigned)
      range_err = (is_signed && sign_bit) ? (upper_bits != upper_mask) : (upper_bits != 7'h00);
      shamt     = is_64 ? 8'd64 : 8'd32;
      if (is_signed && sign_bit) begin
        ext_mask = {MAX_BITS{1'b1}} << shamt;
      end else begin
        ext_mask = '0;
      end
    end else begin
      shamt = {4'd0, index} * 8'd7 + 8'd7;
      if (is_signed && payload[6]) begin
        ext_mask = {MAX_BITS{1'b1}} << shamt;
      end else begin
        ext_mask = '0;
      end
    end
  end

endmodule

// File: rtl/leb128_fetch.sv
// Sequential LEB128 immediate decoder: fetches one genrom window and walks it
// one byte per cycle, returning value, encoded length, next address and error.
module leb128_fetch
  import leb128_pkg::*;
#(
  parameter int AW       = 4,
  parameter int EXTRA    = 4,
  parameter int MAX_BITS = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [AW:0]            addr,
  input  logic                   is_signed,
  input  logic                   is_64,
  output logic                   busy,
  output logic                   done,
  output logic [MAX_BITS-1:0]    value,
  output logic [3:0]             len,
  output logic [AW:0]            next_addr,
  output logic [1:0]             err,
  output logic [AW:0]            mem_addr,
  output logic [EXTRA-1:0]       mem_extra,
  input  logic [(2**EXTRA)*8-1:0] mem_data,
  input  logic                   mem_error
);

  localparam int  ADDR_W    = AW + 1;
  localparam int  WIN_BYTES = 2**EXTRA;
  localparam bit  NARROW    = (MAX_BITS == 32);

  if (WIN_BYTES < max_bytes(MAX_BITS)) begin : g_window_too_small
    $error("leb128_fetch: window of 2**EXTRA bytes cannot hold a MAX_BITS encoding");
  end
  if (MAX_BITS != 32 && MAX_BITS != 64) begin : g_bad_width
    $error("leb128_fetch: MAX_BITS must be 32 or 64");
  end

  fetch_state_t            state;
  logic [AW:0]             req_addr;
  logic                    req_signed;
  logic                    req_64;
  logic [WIN_BYTES*8-1:0]  window;
  logic [MAX_BITS-1:0]     acc;
  logic [3:0]              idx;

  logic [7:0]              cur_byte;
  logic [7:0]              shamt;
  logic [MAX_BITS-1:0]     acc_next;
  logic [3:0]              len_next;
  logic                    is_last;
  logic                    range_err;
  logic [MAX_BITS-1:0]     ext_mask;

  // Current byte of the latched window and the accumulator with its payload merged in
  always_comb begin
    cur_byte = window[int'(idx)*8 +: 8];
    shamt    = {4'd0, idx} * 8'd7;
    acc_next = acc | ({{(MAX_BITS-7){1'b0}}, cur_byte[6:0]} << shamt);
    len_next = idx + 4'd1;
    is_last  = (idx == (req_64 ? 4'd9 : 4'd4));
  end

  leb128_final_check #(.MAX_BITS(MAX_BITS)) u_final_check (
    .payload   (cur_byte[6:0]),
    .index     (idx),
    .is_64     (req_64),
    .is_signed (req_signed),
    .range_err (range_err),
    .ext_mask  (ext_mask)
  );

  // Fetch/decode sequencer; all outputs are registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      value      <= '0;
      len        <= 4'd0;
      next_addr  <= '0;
      err        <= OK;
      mem_addr   <= '0;
      mem_extra  <= '0;
      req_addr   <= '0;
      req_signed <= 1'b0;
      req_64     <= 1'b0;
      window     <= '0;
      acc        <= '0;
      idx        <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            req_addr   <= addr;
            req_signed <= is_signed;
            req_64     <= is_64;
            acc        <= '0;
            idx        <= 4'd0;
            busy       <= 1'b1;
            if (NARROW && is_64) begin
              state     <= DONE;
              done      <= 1'b1;
              err       <= RANGE;
              value     <= '0;
              len       <= 4'd0;
              next_addr <= addr;
            end else begin
              state     <= REQ;
              mem_addr  <= addr;
              mem_extra <= EXTRA'(is_64 ? 4'd9 : 4'd4);
            end
          end else begin
            state <= IDLE;
          end
        end
        REQ: begin
          state <= LATCH;
        end
        LATCH: begin
          window <= mem_data;
          if (mem_error) begin
            state     <= DONE;
            done      <= 1'b1;
            err       <= MEM;
            value     <= '0;
            len       <= 4'd0;
            next_addr <= req_addr;
          end else begin
            state <= DECODE;
          end
        end
        DECODE: begin
          acc <= acc_next;
          idx <= len_next;
          if (!cur_byte[7] || is_last) begin
            state     <= DONE;
            done      <= 1'b1;
            len       <= len_next;
            next_addr <= req_addr + ADDR_W'(len_next);
            if (cur_byte[7]) begin
              err   <= TOO_LONG;
              value <= '0;
            end else if (range_err) begin
              err   <= RANGE;
              value <= '0;
            end else begin
              err   <= OK;
              value <= acc_next | ext_mask;
            end
          end else begin
            state <= DECODE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
